key_expansion_seq: RTL and testbench
====================================

Name: key_expansion_seq

Overview:
- Iterative AES-128 key schedule that sits directly upstream of the encryption round sub-blocks and drives their 128-bit round_key input.
- Accepts a cipher key on a start pulse and derives round keys 1..10 at one key per cycle. Stores all 11 keys (0..10) in an internal buffer.
- The round controller then reads any key by index through a registered read port, one key per cycle.

Parameters:
- NR, 10, number of rounds. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to expand cipher_key. Sampled only in IDLE or DONE.
- cipher_key  input  128  AES key. Bits [127:120] = byte 0 = MSB of w0. Sampled on the start edge.
- busy  output  1  high while expansion is in progress.
- keys_valid  output  1  high when all 11 keys in the buffer belong to the last accepted key.
- rk_index  input  4  round key select, 0..10.
- round_key  output  128  registered read data for rk_index.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, busy=0, keys_valid=0, round_key=0.
  - All 11 buffer slots=0, rcon=8'h01, round counter=0.
  - Reset mid-expansion aborts the expansion and clears everything; no partial keys are retained.
- States: IDLE, EXPAND, DONE.
- IDLE/DONE with start=1, edge T:
  - slot0 <= cipher_key, counter <= 1, rcon <= 8'h01.
  - state -> EXPAND, busy -> 1, keys_valid -> 0.
- EXPAND, each edge T+i for i = 1..10:
  - slot[i] <= f(slot[i-1], rcon).
  - rcon <= xtime(rcon): left shift, XOR 8'h1B if the MSB was set.
  - counter increments.
- Edge T+10: state -> DONE, busy -> 0, keys_valid -> 1.
  - busy is therefore high for exactly 10 cycles.
  - Total start-to-keys_valid latency is 11 edges.
- Key-schedule function f(prev), with prev = {w0, w1, w2, w3}:
  - t = SubWord(RotWord(w3)) XOR {rcon, 24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - SubWord uses the existing sub_bytes S-box: apply it to {RotWord(w3), 96'h0} and take bits [127:96].
- Rcon sequence across rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- start while in EXPAND: ignored. No restart and no queuing.
- start in DONE: restarts expansion. keys_valid drops on that same edge.
- Read port:
  - Every edge, round_key <= slot[rk_index] if rk_index <= 10, else 128'h0. One-cycle latency, always enabled.
  - Reads during EXPAND are legal. They return current slot contents, which may be stale or zero.
  - Read and write of the same slot on the same edge returns the pre-write value.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle: rst pulse -> busy=0, keys_valid=0, round_key=0. rk_index=5 for 3 cycles -> round_key stays 0.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - busy high exactly 10 cycles, keys_valid rises 11 edges after start.
  - rk_index=0 -> 2b7e1516..., rk_index=1 -> a0fafe1788542cb123a339392a6c7605, rk_index=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Each value appears one cycle after the index is applied.
- Key 000102030405060708090a0b0c0d0e0f started from DONE:
  - keys_valid drops on the start edge.
  - After completion, rk_index=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- start re-asserted on cycles T+3 and T+7 of an expansion -> ignored. Timing and final keys are identical to the uninterrupted run.
- rst asserted at T+5 mid-expansion -> outputs and buffer cleared immediately. A new start yields correct keys with no residue from the aborted run.
- rk_index=11 and 15 -> round_key=0. Sweep rk_index 0..10 back-to-back in DONE -> 11 consecutive correct keys, one per cycle.

Source files
------------

// File: rtl/key_expansion_seq.sv
// Iterative AES-128 key schedule with an 11-slot round key buffer.
// One round key per cycle after start; registered read port by index.
module key_expansion_seq #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rk_index,
  output logic [127:0] round_key
);

  localparam int NK = NR + 1;
  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // AES forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(
    input logic [31:0] w
  );
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] r
  );
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] next_key(
    input logic [127:0] prev,
    input logic [7:0]   rc
  );
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word(rot_word(prev[31:0])) ^ {rc, 24'h0};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64]  ^ n0;
    n2 = prev[63:32]  ^ n1;
    n3 = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [3:0]   ctr_q, ctr_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         kv_q, kv_d;
  logic [127:0] slot_q [NK];
  logic [127:0] slot_d [NK];
  logic [127:0] rk_q, rk_d;
  logic [127:0] prev;

  // Previous round key feeding the schedule step for slot ctr_q.
  always_comb begin
    prev = slot_q[0];
    for (int i = 1; i < NK; i++) begin
      if (ctr_q == 4'(i)) prev = slot_q[i-1];
    end
  end

  // Controller: accept a key, then fill one slot per cycle.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    rcon_d  = rcon_q;
    kv_d    = kv_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          slot_d[0] = cipher_key;
          ctr_d     = 4'd1;
          rcon_d    = 8'h01;
          state_d   = EXPAND;
          kv_d      = 1'b0;
        end
      end
      EXPAND: begin
        for (int i = 1; i < NK; i++) begin
          if (ctr_q == 4'(i)) begin
            slot_d[i] = next_key(prev, rcon_q);
          end
        end
        rcon_d = xtime(rcon_q);
        ctr_d  = ctr_q + 4'd1;
        if (ctr_q == LAST) begin
          state_d = DONE;
          kv_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read port mux; out-of-range indices read as zero.
  always_comb begin
    rk_d = '0;
    for (int i = 0; i < NK; i++) begin
      if (rk_index == 4'(i)) rk_d = slot_q[i];
    end
  end

  // State, buffer and read register; reset clears all key material.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      rcon_q  <= 8'h01;
      kv_q    <= 1'b0;
      rk_q    <= '0;
      for (int i = 0; i < NK; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      rcon_q  <= rcon_d;
      kv_q    <= kv_d;
      rk_q    <= rk_d;
      for (int i = 0; i < NK; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign busy       = (state_q == EXPAND);
  assign keys_valid = kv_q;
  assign round_key  = rk_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq using FIPS-197 vectors.
// Immediate assertions at each comparison point.
module tb_key_expansion_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] cipher_key;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_index;
  logic [127:0] round_key;

  int checks = 0;
  int errors = 0;

  logic [127:0] fips [0:10];
  logic [127:0] k2_r1, k2_r10;
  int nb, edges;

  key_expansion_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cipher_key(cipher_key),
    .busy      (busy),
    .keys_valid(keys_valid),
    .rk_index  (rk_index),
    .round_key (round_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_key(
    input string        tag,
    input int           idx,
    input logic [127:0] exp
  );
    rk_index = 4'(idx);
    tick();
    check(tag, round_key, exp);
  endtask

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    k2_r1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    k2_r10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    rst = 1'b0;
    start = 1'b0;
    cipher_key = '0;
    rk_index = 4'd0;
    #2 rst = 1'b1;
    #1;
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_kv", {127'b0, keys_valid}, 128'd0);
    check("rst_rk", round_key, 128'd0);
    tick();
    tick();
    rst = 1'b0;

    rk_index = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_rk5", round_key, 128'd0);
    end

    // First expansion of the FIPS-197 key.
    cipher_key = fips[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s1_busy", {127'b0, busy}, 128'd1);
    check("s1_kv", {127'b0, keys_valid}, 128'd0);
    nb = 1;
    edges = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      edges++;
      if (!busy) break;
      nb++;
    end
    check("s1_busy_cycles", 128'(nb), 128'd10);
    check("s1_latency", 128'(edges), 128'd11);
    check("s1_kv_done", {127'b0, keys_valid}, 128'd1);

    read_key("s1_rk0", 0, fips[0]);
    rk_index = 4'd1;
    #1;
    check("s1_rk_latency", round_key, fips[0]);
    tick();
    check("s1_rk1", round_key, fips[1]);
    read_key("s1_rk10", 10, fips[10]);

    for (int i = 0; i <= 10; i++) begin
      read_key($sformatf("sweep_rk%0d", i), i, fips[i]);
    end
    read_key("rk11", 11, 128'd0);
    read_key("rk15", 15, 128'd0);

    // Restart from DONE with the appendix C.1 key.
    cipher_key = 128'h000102030405060708090a0b0c0d0e0f;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s2_kv_drop", {127'b0, keys_valid}, 128'd0);
    check("s2_busy", {127'b0, busy}, 128'd1);
    repeat (10) tick();
    check("s2_kv_done", {127'b0, keys_valid}, 128'd1);
    check("s2_busy_done", {127'b0, busy}, 128'd0);
    read_key("s2_rk0", 0, cipher_key);
    read_key("s2_rk1", 1, k2_r1);
    read_key("s2_rk10", 10, k2_r10);

    // Start pulses mid-expansion must be ignored.
    cipher_key = fips[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      start = (i == 3 || i == 7);
      cipher_key = start ? 128'hdeadbeef : fips[0];
      tick();
      check($sformatf("ign_busy_t%0d", i),
            {127'b0, busy}, {127'b0, i < 10});
    end
    start = 1'b0;
    check("ign_kv", {127'b0, keys_valid}, 128'd1);
    read_key("ign_rk0", 0, fips[0]);
    read_key("ign_rk1", 1, fips[1]);
    read_key("ign_rk10", 10, fips[10]);

    // Reset in the middle of an expansion.
    cipher_key = 128'h000102030405060708090a0b0c0d0e0f;
    rk_index = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {127'b0, busy}, 128'd0);
    check("mid_rst_kv", {127'b0, keys_valid}, 128'd0);
    check("mid_rst_rk", round_key, 128'd0);
    tick();
    rst = 1'b0;
    read_key("clr_rk0", 0, 128'd0);
    read_key("clr_rk1", 1, 128'd0);
    read_key("clr_rk4", 4, 128'd0);
    read_key("clr_rk10", 10, 128'd0);

    cipher_key = fips[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("post_kv", {127'b0, keys_valid}, 128'd1);
    read_key("post_rk0", 0, fips[0]);
    read_key("post_rk1", 1, fips[1]);
    read_key("post_rk4", 4, fips[4]);
    read_key("post_rk10", 10, fips[10]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
